// File: rtl/fetch_controller_pkg.sv
// Shared encodings for the fetch controller: program_counter mux selects and
// the fetch sequencer states.
package fetch_controller_pkg;

    localparam int          FC_XLEN      = 32;
    localparam logic [31:0] FC_RESET_NOP = 32'h0000_0013;

    // Select encodings understood by program_counter.
    typedef enum logic [1:0] {
        PC_MUX_PC4      = 2'b00,
        PC_MUX_ALU_OUT  = 2'b01,
        PC_MUX_PC_ADDER = 2'b10
    } pc_mux_e;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_WAIT = 2'b10,
        FETCH_HOLD = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding req/gnt transfer to imem, a
// registered decode buffer with skid slot, and execute-stage redirect handling.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int              XLEN      = FC_XLEN,
    parameter logic [XLEN-1:0] RESET_NOP = XLEN'(FC_RESET_NOP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    output logic [1:0]      pc_sel,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [1:0]      redirect_sel,
    input  logic            stall,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] skid_q, skid_d;

    logic buf_free;
    logic redirect_active;

    // The buffer can take a word if it is empty or is being consumed now.
    assign buf_free        = !if_valid_q || !stall;
    assign redirect_active = redirect && (state_q != FETCH_BOOT);
    assign imem_addr       = pc;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        req_pc_d   = req_pc_q;
        skid_d     = skid_q;
        pc_en      = 1'b0;
        pc_sel     = PC_MUX_PC4;
        imem_req   = 1'b0;

        if (if_valid_q && !stall) begin
            if_valid_d = 1'b0;
        end

        if (redirect_active) begin
            pc_en      = 1'b1;
            pc_sel     = redirect_sel;
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            FETCH_BOOT: begin
                state_d = FETCH_REQ;
            end

            FETCH_REQ: begin
                if (!redirect_active) begin
                    imem_req = buf_free;
                    if (buf_free && imem_gnt) begin
                        req_pc_d = pc;
                        state_d  = FETCH_WAIT;
                    end
                end
            end

            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_active || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else if (buf_free) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = req_pc_q;
                        pc_en      = 1'b1;
                        state_d    = FETCH_REQ;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = FETCH_HOLD;
                    end
                end else if (redirect_active) begin
                    // Response still in flight: mark it stale for when it lands.
                    kill_d = 1'b1;
                end
            end

            FETCH_HOLD: begin
                if (redirect_active) begin
                    state_d = FETCH_REQ;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_instr_d = skid_q;
                    if_pc_d    = req_pc_q;
                    pc_en      = 1'b1;
                    state_d    = FETCH_REQ;
                end
            end

            default: begin
                state_d = FETCH_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= FETCH_BOOT;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= RESET_NOP;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    // NOTE: pure datapath holding registers are left without reset; they are
    // only read after the control state has written them.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        skid_q   <= skid_d;
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a behavioural program_counter
// and a fixed-latency instruction memory responder.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
    localparam logic [31:0] ALU_TARGET   = 32'h0000_1000;
    localparam logic [31:0] ADDER_TARGET = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [1:0]  redirect_sel = 2'b00;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_exp_t;

    logic [31:0] exp_addr_q[$];
    if_exp_t     exp_if_q[$];
    int          grant_cyc[$];

    int checks    = 0;
    int failures  = 0;
    int grant_cnt = 0;
    int cyc       = 0;
    int mem_lat   = 1;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_sel(redirect_sel),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // program_counter stand-in
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'h0;
        end else if (pc_en) begin
            case (pc_sel)
                PC_MUX_PC4:      pc <= pc + 32'd4;
                PC_MUX_ALU_OUT:  pc <= ALU_TARGET;
                PC_MUX_PC_ADDER: pc <= ADDER_TARGET;
                default:         pc <= 32'hDEAD_BEEF;
            endcase
        end
    end

    // imem responder: not reset, so an in-flight response can land during rst
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr_q = 32'h0;
    int          mem_cnt = 0;

    assign imem_rvalid = mem_pend && (mem_cnt == 0);
    assign imem_rdata  = instr_of(mem_addr_q);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_rvalid) begin
            mem_pend <= 1'b0;
        end else if (mem_pend) begin
            mem_cnt <= mem_cnt - 1;
        end
        if (imem_req && imem_gnt) begin
            mem_pend   <= 1'b1;
            mem_addr_q <= imem_addr;
            mem_cnt    <= mem_lat - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer.
    if_exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_gnt) begin
                grant_cnt++;
                grant_cyc.push_back(cyc);
                check("grant_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check("grant_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (if_valid && !stall) begin
                check("consume_expected", 32'(exp_if_q.size() != 0), 32'd1);
                if (exp_if_q.size() != 0) begin
                    mon_e = exp_if_q.pop_front();
                    check("if_pc", if_pc, mon_e.pc);
                    check("if_instr", if_instr, mon_e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input logic [31:0] a);
        if_exp_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        exp_if_q.push_back(e);
    endtask

    task automatic wait_grants(input int target, input string name);
        int budget = 60;
        while (grant_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_grant_wait"}, 32'(grant_cnt >= target), 32'd1);
    endtask

    task automatic drain(input string name);
        int budget = 60;
        while (exp_if_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
        check({name, "_if_drained"}, 32'(exp_if_q.size()), 32'd0);
        check({name, "_addr_drained"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pc_en"}, 32'(pc_en), 32'd0);
        check({name, "_pc_sel"}, 32'(pc_sel), 32'(PC_MUX_PC4));
        check({name, "_imem_req"}, 32'(imem_req), 32'd0);
        check({name, "_if_valid"}, 32'(if_valid), 32'd0);
        check({name, "_if_instr"}, if_instr, NOP_WORD);
        check({name, "_if_pc"}, if_pc, 32'h0);
    endtask

    task automatic do_reset(input logic gnt_v, input logic stall_v);
        rst      = 1'b1;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        stall    = 1'b0;
        repeat (3) tick();
        imem_gnt = gnt_v;
        stall    = stall_v;
        rst      = 1'b0;
    endtask

    initial begin
        int base;

        // reset state
        repeat (2) tick();
        check_reset_outputs("reset");

        // 1: back-to-back fetch, addresses 0,4,8 every two cycles
        mem_lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        push_if(32'h0);
        push_if(32'h4);
        push_if(32'h8);
        base = grant_cnt;
        do_reset(1'b1, 1'b0);
        wait_grants(base + 3, "t1");
        imem_gnt = 1'b0;
        drain("t1");
        check("t1_gap01", 32'(grant_cyc[base + 1] - grant_cyc[base]), 32'd2);
        check("t1_gap12", 32'(grant_cyc[base + 2] - grant_cyc[base + 1]), 32'd2);

        // 2: stall holds the buffer, no pc_en and no request while held
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        push_if(32'h0);
        push_if(32'h4);
        base = grant_cnt;
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 20 && !if_valid; i++) tick();
        for (int i = 0; i < 6; i++) begin
            check("t2_if_valid_held", 32'(if_valid), 32'd1);
            check("t2_if_pc_held", if_pc, 32'h0);
            check("t2_no_pc_en", 32'(pc_en), 32'd0);
            check("t2_no_req", 32'(imem_req), 32'd0);
            tick();
        end
        stall = 1'b0;
        wait_grants(base + 2, "t2");
        imem_gnt = 1'b0;
        drain("t2");

        // 3: redirect to ALU target while waiting; late response is dropped
        mem_lat = 3;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(ALU_TARGET);
        push_if(ALU_TARGET);
        base = grant_cnt;
        do_reset(1'b1, 1'b0);
        wait_grants(base + 1, "t3a");
        redirect     = 1'b1;
        redirect_sel = PC_MUX_ALU_OUT;
        #1;
        check("t3_pc_en", 32'(pc_en), 32'd1);
        check("t3_pc_sel", 32'(pc_sel), 32'(PC_MUX_ALU_OUT));
        check("t3_no_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        wait_grants(base + 2, "t3b");
        imem_gnt = 1'b0;
        drain("t3");

        // 4: redirect coincides with rvalid; stale word never reaches decode
        mem_lat = 1;
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(ADDER_TARGET);
        push_if(ADDER_TARGET);
        base = grant_cnt;
        do_reset(1'b1, 1'b0);
        wait_grants(base + 1, "t4a");
        check("t4_rvalid_now", 32'(imem_rvalid), 32'd1);
        redirect     = 1'b1;
        redirect_sel = PC_MUX_PC_ADDER;
        #1;
        check("t4_pc_en", 32'(pc_en), 32'd1);
        check("t4_pc_sel", 32'(pc_sel), 32'(PC_MUX_PC_ADDER));
        tick();
        redirect = 1'b0;
        check("t4_no_stale", 32'(if_valid), 32'd0);
        wait_grants(base + 2, "t4b");
        imem_gnt = 1'b0;
        drain("t4");

        // 5: grant withheld, request and address held steady
        exp_addr_q.push_back(32'h0);
        push_if(32'h0);
        base = grant_cnt;
        do_reset(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_req_held", 32'(imem_req), 32'd1);
            check("t5_addr_stable", imem_addr, 32'h0);
            check("t5_no_pc_en", 32'(pc_en), 32'd0);
            tick();
        end
        imem_gnt = 1'b1;
        wait_grants(base + 1, "t5");
        imem_gnt = 1'b0;
        drain("t5");

        // 6: reset while waiting; response lands during reset and is ignored
        mem_lat = 3;
        exp_addr_q.push_back(32'h0);
        base = grant_cnt;
        do_reset(1'b1, 1'b0);
        wait_grants(base + 1, "t6a");
        rst      = 1'b1;
        imem_gnt = 1'b0;
        repeat (4) tick();
        check_reset_outputs("t6_rst");
        mem_lat = 1;
        exp_addr_q.push_back(32'h0);
        push_if(32'h0);
        imem_gnt = 1'b1;
        rst      = 1'b0;
        wait_grants(base + 2, "t6b");
        imem_gnt = 1'b0;
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
